// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer
// Sequences the pixel-fetch datapath for one blade position. Each new blade
// position starts a sweep over every LED index and, for each LED, every fetch
// subcycle. After the sweep, a short drain lets the fetch pipeline flush. The
// block then waits for the LED shift register to go idle before it accepts
// the next sweep. It also arbitrates the single image RAM port between the
// fetch datapath (while fetching) and the image-loader write path (otherwise).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   new_position      one-cycle pulse, blade reached position_in
//   position_in       blade position sampled with new_position
//   shift_busy        LED shift register still shifting
//   fetch_ram_addr    RAM address from the fetch datapath
//   wr_req            loader write request, held until wr_ack
//   wr_addr/wr_wdata  loader write address and data
//   position          position currently being fetched
//   led/led_subcycle  current LED index and subcycle within that LED
//   fetch_active      high while sweeping or draining
//   missed_position   pulse, a pending position was overwritten
//   wr_ack            pulse, loader write performed this cycle
//   ram_addr/ram_wdata/ram_we  shared image RAM port
module fetch_sequencer #(
    parameter int NB_LEDS      = 128,
    parameter int NB_SUBCYCLES = 12,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_position,
    input  logic [9:0]  position_in,
    input  logic        shift_busy,
    input  logic [18:0] fetch_ram_addr,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [7:0]  wr_wdata,
    output logic [9:0]  position,
    output logic [6:0]  led,
    output logic [3:0]  led_subcycle,
    output logic        fetch_active,
    output logic        missed_position,
    output logic        wr_ack,
    output logic [18:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [6:0]         LED_LAST   = 7'(NB_LEDS - 1);
    localparam logic [3:0]         SUB_LAST   = 4'(NB_SUBCYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        WAIT_SHIFT
    } state_t;

    state_t             state;
    logic               pending;
    logic [9:0]         pending_pos;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [18:0]        wr_addr_q;
    logic               sweep_start;
    logic               write_grant;

    // A sweep starts from IDLE on a fresh pulse or on a position that arrived
    // while the previous sweep was still busy.
    assign sweep_start = (state == IDLE) && (new_position || pending);

    // Loader writes only use the RAM while the fetch path is not running. A
    // sweep start wins the cycle, and the wr_ack term stops a held request
    // from being granted twice. A write granted in WAIT_SHIFT completes in
    // the following IDLE cycle, so it always finishes before a sweep can
    // take the address bus.
    assign write_grant = ((state == IDLE) || (state == WAIT_SHIFT)) &&
                         wr_req && !wr_ack && !sweep_start;

    // The fetch address passes through combinationally because the datapath
    // computes it in the same cycle it expects the read.
    assign ram_addr = fetch_active ? fetch_ram_addr : wr_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= 1'b0;
            pending_pos     <= '0;
            drain_cnt       <= '0;
            wr_addr_q       <= '0;
            position        <= '0;
            led             <= '0;
            led_subcycle    <= '0;
            fetch_active    <= 1'b0;
            missed_position <= 1'b0;
            wr_ack          <= 1'b0;
            ram_wdata       <= '0;
            ram_we          <= 1'b0;
        end else begin
            // Any new pulse that arrives while a position is still pending
            // drops that position, both when busy and in IDLE.
            missed_position <= new_position && pending;

            wr_ack <= write_grant;
            ram_we <= write_grant;
            if (write_grant) begin
                wr_addr_q <= wr_addr;
                ram_wdata <= wr_wdata;
            end

            // A pulse that cannot start a sweep right now is queued. Only the
            // most recent one is kept.
            if (new_position && !sweep_start) begin
                pending     <= 1'b1;
                pending_pos <= position_in;
            end

            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state        <= SWEEP;
                        position     <= new_position ? position_in : pending_pos;
                        pending      <= 1'b0;
                        led          <= '0;
                        led_subcycle <= '0;
                        fetch_active <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (led_subcycle == SUB_LAST) begin
                        if (led == LED_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            led          <= led + 7'd1;
                            led_subcycle <= '0;
                        end
                    end else begin
                        led_subcycle <= led_subcycle + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= WAIT_SHIFT;
                        fetch_active <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                WAIT_SHIFT: begin
                    if (!shift_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A behavioural model tracks each
// sweep as a cycle count since its start. LED and subcycle come from
// division and modulo of that count. Pending positions, write grants and the
// shift wait are kept as plain flags. Directed sequences come first, then a
// randomized run.
module tb_fetch_sequencer;

    localparam int NB_LEDS      = 128;
    localparam int NB_SUBCYCLES = 12;
    localparam int DRAIN_CYCLES = 3;
    localparam int SWEEP_LEN    = NB_LEDS * NB_SUBCYCLES;
    localparam int FETCH_LEN    = SWEEP_LEN + DRAIN_CYCLES;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_position = 1'b0;
    logic [9:0]  position_in = '0;
    logic        shift_busy = 1'b0;
    logic [18:0] fetch_ram_addr = '0;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_wdata = '0;
    logic [9:0]  position;
    logic [6:0]  led;
    logic [3:0]  led_subcycle;
    logic        fetch_active;
    logic        missed_position;
    logic        wr_ack;
    logic [18:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;

    fetch_sequencer #(
        .NB_LEDS(NB_LEDS),
        .NB_SUBCYCLES(NB_SUBCYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .new_position(new_position),
        .position_in(position_in),
        .shift_busy(shift_busy),
        .fetch_ram_addr(fetch_ram_addr),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_wdata(wr_wdata),
        .position(position),
        .led(led),
        .led_subcycle(led_subcycle),
        .fetch_active(fetch_active),
        .missed_position(missed_position),
        .wr_ack(wr_ack),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int active_cycles = 0;
    int missed_cnt = 0;
    int ack_cnt = 0;

    // Model state. m_t is -1 when no sweep is in progress. It counts cycles
    // since the sweep started, and values at or above FETCH_LEN mean the
    // model is waiting for the shift register. m_prog is the sweep progress,
    // saturating at the last subcycle of the last LED.
    int          m_t;
    int          m_prog;
    logic [9:0]  m_pos;
    logic [9:0]  m_ppos;
    bit          m_pend;
    bit          m_missed;
    bit          m_ack;
    logic [18:0] m_waddr;
    logic [7:0]  m_wdata;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_t      = -1;
        m_prog   = 0;
        m_pos    = '0;
        m_ppos   = '0;
        m_pend   = 0;
        m_missed = 0;
        m_ack    = 0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic modelStep();
        bit idle;
        bit waiting;
        bit start;
        bit grant;
        idle    = (m_t < 0);
        waiting = (m_t >= FETCH_LEN);
        start   = idle && (new_position || m_pend);
        grant   = (idle || waiting) && wr_req && !m_ack && !start;
        m_missed = new_position && m_pend;
        m_ack    = grant;
        if (grant) begin
            m_waddr = wr_addr;
            m_wdata = wr_wdata;
        end
        if (start) begin
            m_pos  = new_position ? position_in : m_ppos;
            m_pend = 0;
            m_t    = 0;
            m_prog = 0;
        end else begin
            if (new_position) begin
                m_pend = 1;
                m_ppos = position_in;
            end
            if (!idle && !waiting) begin
                m_t++;
                if (m_prog < SWEEP_LEN - 1) m_prog++;
            end else if (waiting && !shift_busy) begin
                m_t = -1;
            end
        end
    endtask

    task automatic compareAll();
        bit exp_active;
        exp_active = (m_t >= 0) && (m_t < FETCH_LEN);
        checkOutput("position", 32'(position), 32'(m_pos));
        checkOutput("led", 32'(led), 32'(m_prog / NB_SUBCYCLES));
        checkOutput("led_subcycle", 32'(led_subcycle), 32'(m_prog % NB_SUBCYCLES));
        checkOutput("fetch_active", 32'(fetch_active), 32'(exp_active));
        checkOutput("missed_position", 32'(missed_position), 32'(m_missed));
        checkOutput("wr_ack", 32'(wr_ack), 32'(m_ack));
        checkOutput("ram_we", 32'(ram_we), 32'(m_ack));
        checkOutput("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        checkOutput("ram_addr", 32'(ram_addr),
                    32'(exp_active ? fetch_ram_addr : m_waddr));
    endtask

    task automatic startWrite(input logic [18:0] addr, input logic [7:0] data);
        wr_req   = 1'b1;
        wr_addr  = addr;
        wr_wdata = data;
    endtask

    // Drive one cycle of inputs from a negedge, check after the posedge and
    // return on the next negedge. The loader drops its request once acked.
    task automatic applyStimulus(input logic np, input logic [9:0] pos,
                                 input logic busy);
        new_position   = np;
        position_in    = pos;
        shift_busy     = busy;
        fetch_ram_addr = 19'($urandom);
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        if (m_ack) wr_req = 1'b0;
        if (fetch_active) active_cycles++;
        if (missed_position) missed_cnt++;
        if (wr_ack) ack_cnt++;
        @(negedge clk);
    endtask

    task automatic runUntilWaiting(input logic busy);
        for (int c = 0; c < FETCH_LEN + 10 && m_t < FETCH_LEN; c++) begin
            applyStimulus(1'b0, 10'h0, busy);
        end
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_position", 32'(position), 32'h0);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_subcycle", 32'(led_subcycle), 32'h0);
        checkOutput("reset_fetch_active", 32'(fetch_active), 32'h0);
        checkOutput("reset_wr_ack", 32'(wr_ack), 32'h0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'h0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loader write while idle.
        startWrite(19'h12345, 8'hA5);
        applyStimulus(1'b0, 10'h0, 1'b0);
        checkOutput("idle_write_ack", 32'(wr_ack), 32'h1);
        checkOutput("idle_write_we", 32'(ram_we), 32'h1);
        checkOutput("idle_write_addr", 32'(ram_addr), 32'h12345);
        checkOutput("idle_write_data", 32'(ram_wdata), 32'hA5);
        applyStimulus(1'b0, 10'h0, 1'b0);
        checkOutput("idle_write_single", 32'(wr_ack), 32'h0);

        // Sweep 1: position 0x155, one extra pulse mid-sweep.
        active_cycles = 0;
        missed_cnt = 0;
        applyStimulus(1'b1, 10'h155, 1'b0);
        checkOutput("sweep1_position", 32'(position), 32'h155);
        checkOutput("sweep1_first_led", 32'(led), 32'h0);
        for (int c = 0; c < FETCH_LEN + 10 && m_t < FETCH_LEN; c++) begin
            if (m_prog == 300) applyStimulus(1'b1, 10'h010, 1'b1);
            else applyStimulus(1'b0, 10'h0, 1'b1);
        end
        checkOutput("sweep1_fetch_cycles", 32'(active_cycles), 32'(FETCH_LEN));
        checkOutput("sweep1_led_hold", 32'(led), 32'd127);
        checkOutput("sweep1_sub_hold", 32'(led_subcycle), 32'd11);
        checkOutput("sweep1_no_missed", 32'(missed_cnt), 32'h0);

        // Shift register still busy for 20 cycles.
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, 10'h0, 1'b1);
        checkOutput("wait_shift_hold", 32'(fetch_active), 32'h0);
        applyStimulus(1'b0, 10'h0, 1'b0);
        applyStimulus(1'b0, 10'h0, 1'b0);
        checkOutput("pending_start_active", 32'(fetch_active), 32'h1);
        checkOutput("pending_start_position", 32'(position), 32'h010);

        // Sweep 2: two pulses (second overwrites) and a write held off.
        missed_cnt = 0;
        ack_cnt = 0;
        for (int c = 0; c < FETCH_LEN + 10 && m_t < FETCH_LEN; c++) begin
            if (m_prog == 200) begin
                applyStimulus(1'b1, 10'h020, 1'b0);
            end else if (m_prog == 400) begin
                applyStimulus(1'b1, 10'h030, 1'b0);
                checkOutput("missed_on_second", 32'(missed_position), 32'h1);
            end else begin
                if (m_prog == 600) startWrite(19'h0ABCD, 8'h3C);
                applyStimulus(1'b0, 10'h0, 1'b0);
            end
        end
        checkOutput("sweep2_missed_count", 32'(missed_cnt), 32'h1);
        checkOutput("sweep2_no_write_during_fetch", 32'(ack_cnt), 32'h0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 10'h0, 1'b1);
        checkOutput("write_served_in_wait", 32'(ack_cnt), 32'h1);
        applyStimulus(1'b0, 10'h0, 1'b0);
        applyStimulus(1'b0, 10'h0, 1'b0);
        checkOutput("sweep3_position", 32'(position), 32'h030);

        // Sweep 3: queue a position, then reset asynchronously at LED 60.
        for (int c = 0; c < FETCH_LEN && m_prog != 60 * NB_SUBCYCLES; c++) begin
            if (m_prog == 100) applyStimulus(1'b1, 10'h2AA, 1'b0);
            else applyStimulus(1'b0, 10'h0, 1'b0);
        end
        checkOutput("reset_point_led", 32'(led), 32'd60);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_position", 32'(position), 32'h0);
        checkOutput("async_led", 32'(led), 32'h0);
        checkOutput("async_fetch_active", 32'(fetch_active), 32'h0);
        checkOutput("async_ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("async_ram_wdata", 32'(ram_wdata), 32'h0);
        modelReset();
        wr_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 10'h0, 1'b1);
        checkOutput("pending_cleared_by_reset", 32'(fetch_active), 32'h0);

        // New pulse arriving in IDLE while a position is still pending.
        applyStimulus(1'b1, 10'h0F0, 1'b0);
        for (int c = 0; c < 50; c++) applyStimulus(1'b0, 10'h0, 1'b0);
        applyStimulus(1'b1, 10'h111, 1'b0);
        runUntilWaiting(1'b1);
        applyStimulus(1'b0, 10'h0, 1'b0);
        applyStimulus(1'b1, 10'h3FF, 1'b0);
        checkOutput("idle_overwrite_missed", 32'(missed_position), 32'h1);
        checkOutput("idle_overwrite_position", 32'(position), 32'h3FF);

        // Randomized traffic.
        for (int c = 0; c < 10000; c++) begin
            logic np;
            logic busy;
            np   = ($urandom_range(0, 499) == 0);
            busy = ($urandom_range(0, 3) != 0);
            if (!wr_req && $urandom_range(0, 9) == 0)
                startWrite(19'($urandom), 8'($urandom));
            applyStimulus(np, 10'($urandom), busy);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
